alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
Execute-stage controller that sits directly upstream of the 16-bit ALU (dALU) and consumes its result and flags.
- Accepts one two-operand instruction at a time over a valid/ready handshake.
- Reads operands from an internal 8x16 register file and drives the ALU A/B/op inputs.
- Captures the ALU out/flags and writes them back to the destination register and a flags register.
- Provides the sequencing and architectural state that the combinational ALU lacks.

Parameters:
- NREGS, 8, number of 16-bit general registers; the address width is 3 bits at the default.
- MAX_OP, 7, highest legal opcode; opcodes above this value are illegal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- instr_valid  input  1  instruction fields are valid.
- instr_ready  output  1  controller can accept an instruction.
- instr_op  input  4  ALU opcode: 0 PASS, 1 OR, 2 AND, 3 XOR, 4 NOT, 5 ADD, 6 SUB, 7 SHL.
- instr_rd  input  3  destination register; also the source for operand A.
- instr_rs  input  3  source register for operand B when instr_imm_en=0.
- instr_imm_en  input  1  1 selects instr_imm as operand B.
- instr_imm  input  16  immediate operand B.
- alu_A  output  16  to ALU A.
- alu_B  output  16  to ALU B.
- alu_op  output  4  to ALU op.
- alu_out  input  16  from ALU out.
- alu_flags  input  4  from ALU flags: bit0 zero, bit1 carry, bit2 sign, bit3 overflow.
- flags_q  output  4  architectural flags register.
- done  output  1  one-cycle pulse on writeback or on illegal-op retire.
- err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.
- dbg_addr  input  3  debug register read address.
- dbg_data  output  16  combinational read of R[dbg_addr].

Behaviour:
- Reset (rst_n=0 at an edge):
  - state goes to IDLE; all R[i], flags_q and the latched instruction fields become 0; done=0, err=0.
  - instr_ready=0 in any cycle where rst_n=0.
  - Reset mid-operation abandons the instruction: no register or flag write, no done pulse.
- States and transitions:
  - IDLE: instr_ready=1. If instr_valid, latch op, rd, and B-source (either the immediate value or the rs index, plus imm_en), then go to EXEC. If not valid, stay in IDLE.
  - EXEC: instr_ready=0.
    - Drive alu_A=R[rd_l], alu_B=(imm_en_l ? imm_l : R[rs_l]), alu_op=op_l.
    - Register alu_out into res_q and alu_flags into fl_q; go to WB.
    - If op_l > MAX_OP, skip the capture and go to WB with an illegal marker.
  - WB: instr_ready=0. Pulse done=1.
    - Legal op: R[rd_l] <= res_q and flags_q <= fl_q.
    - Illegal op: no register or flag write; err=1.
    - Always go to IDLE.
- ALU outputs outside EXEC: alu_A/alu_B/alu_op hold the EXEC formula using the latched fields; they are don't-care to downstream logic.
- Timing and throughput:
  - Handshake accepted at edge T; result visible in R/flags_q after edge T+2; done is high in the cycle between T+2 and T+3.
  - Next acceptance is possible at edge T+3, so throughput is one instruction per 3 cycles.
- Handshake rules:
  - instr_valid may be held high while busy; it is ignored until IDLE.
  - Fields are sampled only at the accepting edge; later changes have no effect on the instruction in flight.
- R0 semantics:
  - Reads as 0 everywhere, including operands and dbg_data.
  - Writes to R0 are discarded, but flags_q still updates, so R0 acts as a compare/test destination.
- Operand aliasing: rd==rs is legal; both operands read the same pre-write value.
- Widths: all data is 16 bits and the ALU result is taken as-is; no extension or saturation. A carry out of bit 15 is reported only through flags bit1.
- dbg_data: a combinational read of the current register contents. In the WB cycle it shows the old value; the new value appears after the edge.

Test Plan:
- Accept and ADD: PASS R1,imm 250 then ADD R1,imm 7.
  - R1=257; flags_q zero=0, carry=0.
  - Each instruction: done one cycle; accepted at T, done high during T+2..T+3.
- Zero result: R2=5, SUB R2,R2.
  - R2=0; flags_q zero=1, sign=0.
- Carry out: R3=16'hFFFF, ADD R3,imm 1.
  - R3=0; flags_q zero=1, carry=1.
- Illegal opcode: flags_q=4'b0001, R4=16'h1234, op=9 on R4.
  - done=1 and err=1 for one cycle; R4 still 16'h1234; flags_q still 4'b0001.
- Busy handshake: instr_valid held high with two back-to-back OR instructions.
  - instr_ready low for 2 cycles after the first accept; the second is accepted exactly 3 edges later.
  - Both results are correct.
- Reset and R0 cases:
  - rst_n=0 asserted in EXEC of ADD R5,imm 3 (R5=10 beforehand): all R cleared to 0, no done pulse, next instruction executes normally.
  - PASS R0,imm 16'h8000: R0 reads 0; flags_q sign=1.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the 16-bit dALU.
// Takes one two-operand instruction per handshake and reads its operands
// from an internal register file. It drives the combinational ALU, captures
// the ALU result and flags, then writes them back to the register file and
// the architectural flags register. One instruction retires every 3 cycles.
module alu_exec_ctrl #(
    parameter int NREGS  = 8,
    parameter int MAX_OP = 7,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic          instr_imm_en,
    input  logic [15:0]   instr_imm,
    output logic [15:0]   alu_A,
    output logic [15:0]   alu_B,
    output logic [3:0]    alu_op,
    input  logic [15:0]   alu_out,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags_q,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]   regs [NREGS];

    // Instruction fields latched at the accepting edge
    logic [3:0]    op_l;
    logic [AW-1:0] rd_l;
    logic [AW-1:0] rs_l;
    logic          imm_en_l;
    logic [15:0]   imm_l;

    // Captured ALU result awaiting writeback
    logic [15:0]   res_q;
    logic [3:0]    fl_q;
    logic          ill_q;

    logic [15:0]   op_a;
    logic [15:0]   op_b;
    logic          op_illegal;
    logic          accept;

    // R0 is hard-wired to zero on every read path
    assign op_a       = (rd_l == '0) ? '0 : regs[rd_l];
    assign op_b       = imm_en_l ? imm_l : ((rs_l == '0) ? '0 : regs[rs_l]);
    assign dbg_data   = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    assign op_illegal = (op_l > MAX_OP_L);

    assign alu_A  = op_a;
    assign alu_B  = op_b;
    assign alu_op = op_l;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake output
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = rst_n;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Field latch, ALU capture, writeback and retire pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_l     <= '0;
            rd_l     <= '0;
            rs_l     <= '0;
            imm_en_l <= 1'b0;
            imm_l    <= '0;
            res_q    <= '0;
            fl_q     <= '0;
            ill_q    <= 1'b0;
            flags_q  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // done/err are registered from WB, so they coincide with the
            // cycle in which the written-back value first becomes visible
            done <= (state_q == S_WB);
            err  <= (state_q == S_WB) && ill_q;

            if (accept) begin
                op_l     <= instr_op;
                rd_l     <= instr_rd;
                rs_l     <= instr_rs;
                imm_en_l <= instr_imm_en;
                imm_l    <= instr_imm;
            end

            if (state_q == S_EXEC) begin
                ill_q <= op_illegal;
                if (!op_illegal) begin
                    res_q <= alu_out;
                    fl_q  <= alu_flags;
                end
            end

            if ((state_q == S_WB) && !ill_q) begin
                flags_q <= fl_q;
                if (rd_l != '0) begin
                    regs[rd_l] <= res_q;
                end
            end
        end
    end

endmodule
